// File: rtl/seq_ram_arbiter.sv
// seq_ram_arbiter: shares the single-port sequence RAM between the sequence generator (writes), the game controller and an aux reader (reads).
// Optional macro ARB_RR_EN selects round-robin Ctrl/Aux read arbitration. When it is undefined, Ctrl has fixed priority over Aux.
module seq_ram_arbiter #(
  parameter int RAM_LAT = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              GenReq,
  input  logic [ADDR_W-1:0] GenAddr,
  input  logic [DATA_W-1:0] GenData,
  output logic              GenAck,
  input  logic              CtrlReq,
  input  logic [ADDR_W-1:0] CtrlAddr,
  output logic [DATA_W-1:0] CtrlData,
  output logic              CtrlValid,
  input  logic              AuxReq,
  input  logic [ADDR_W-1:0] AuxAddr,
  output logic [DATA_W-1:0] AuxData,
  output logic              AuxValid,
  output logic [ADDR_W-1:0] RamAddr,
  output logic              RamWe,
  output logic [DATA_W-1:0] RamDin,
  input  logic [DATA_W-1:0] RamDout,
  output logic              Busy,
  output logic              Overrun
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  localparam logic [2:0] LAT = 3'(RAM_LAT);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              win_aux_q, win_aux_d;
  logic              pend_gen_q, pend_gen_d, pend_ctrl_q, pend_ctrl_d, pend_aux_q, pend_aux_d;
  logic              cap_gen, cap_ctrl, cap_aux, ovr_gen, ovr_ctrl, ovr_aux;
  logic              gen_done, ctrl_done, aux_done, pick_aux;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              gen_ack_q, gen_ack_d, ctrl_valid_q, ctrl_valid_d, aux_valid_q, aux_valid_d;
  logic [DATA_W-1:0] ctrl_data_q, ctrl_data_d, aux_data_q, aux_data_d;
  logic [ADDR_W-1:0] gen_addr_h, ctrl_addr_h, aux_addr_h;
  logic [DATA_W-1:0] gen_data_h;
`ifdef ARB_RR_EN
  logic              rr_aux_q, rr_aux_d;
`endif

  // Returns {pend_next, capture, overrun}. Flush discards everything, and a new request wins over a completion.
  function automatic logic [2:0] req_update(input logic req, input logic pend,
                                            input logic done, input logic flush);
    logic [2:0] r;
    r = {pend, 2'b00};
    if (flush)                    r[2] = 1'b0;
    else if (req && (!pend || done)) r = 3'b110;
    else if (req)                 r[0] = 1'b1;
    else if (done)                r[2] = 1'b0;
    return r;
  endfunction

`ifdef ARB_RR_EN
  assign pick_aux = pend_aux_q && (!pend_ctrl_q || rr_aux_q);
`else
  assign pick_aux = pend_aux_q && !pend_ctrl_q;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_aux_d    = win_aux_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_din_d    = ram_din_q;
    gen_ack_d    = 1'b0;
    ctrl_valid_d = 1'b0;
    aux_valid_d  = 1'b0;
    ctrl_data_d  = ctrl_data_q;
    aux_data_d   = aux_data_q;
    gen_done     = 1'b0;
    ctrl_done    = 1'b0;
    aux_done     = 1'b0;
`ifdef ARB_RR_EN
    rr_aux_d     = rr_aux_q;
`endif
    case (state_q)
      IDLE: begin
        // Flush empties the pending set on this edge, so nothing is granted from it.
        if (!Flush) begin
          if (pend_gen_q) begin
            ram_addr_d = gen_addr_h;
            ram_din_d  = gen_data_h;
            ram_we_d   = 1'b1;
            state_d    = WRITE;
          end else if (pend_ctrl_q || pend_aux_q) begin
            ram_addr_d = pick_aux ? aux_addr_h : ctrl_addr_h;
            win_aux_d  = pick_aux;
            cnt_d      = 3'd1;
            state_d    = READ;
`ifdef ARB_RR_EN
            rr_aux_d   = !pick_aux;
`endif
          end
        end
      end
      WRITE: begin
        gen_ack_d = 1'b1;
        gen_done  = 1'b1;
        state_d   = IDLE;
      end
      READ: begin
        if (cnt_q == LAT) begin
          if (win_aux_q) begin
            aux_data_d  = RamDout;
            aux_valid_d = 1'b1;
            aux_done    = 1'b1;
          end else begin
            ctrl_data_d  = RamDout;
            ctrl_valid_d = 1'b1;
            ctrl_done    = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    {pend_gen_d,  cap_gen,  ovr_gen}  = req_update(GenReq,  pend_gen_q,  gen_done,  Flush);
    {pend_ctrl_d, cap_ctrl, ovr_ctrl} = req_update(CtrlReq, pend_ctrl_q, ctrl_done, Flush);
    {pend_aux_d,  cap_aux,  ovr_aux}  = req_update(AuxReq,  pend_aux_q,  aux_done,  Flush);
    overrun_d = overrun_q | ovr_gen | ovr_ctrl | ovr_aux;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      win_aux_q    <= 1'b0;
      pend_gen_q   <= 1'b0;
      pend_ctrl_q  <= 1'b0;
      pend_aux_q   <= 1'b0;
      overrun_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_din_q    <= '0;
      gen_ack_q    <= 1'b0;
      ctrl_valid_q <= 1'b0;
      aux_valid_q  <= 1'b0;
      ctrl_data_q  <= '0;
      aux_data_q   <= '0;
`ifdef ARB_RR_EN
      rr_aux_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_aux_q    <= win_aux_d;
      pend_gen_q   <= pend_gen_d;
      pend_ctrl_q  <= pend_ctrl_d;
      pend_aux_q   <= pend_aux_d;
      overrun_q    <= overrun_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_din_q    <= ram_din_d;
      gen_ack_q    <= gen_ack_d;
      ctrl_valid_q <= ctrl_valid_d;
      aux_valid_q  <= aux_valid_d;
      ctrl_data_q  <= ctrl_data_d;
      aux_data_q   <= aux_data_d;
`ifdef ARB_RR_EN
      rr_aux_q     <= rr_aux_d;
`endif
    end
  end

  // Holding registers are only read while their pending flag is set, so they need no reset.
  always_ff @(posedge Clk) begin
    if (cap_gen) begin
      gen_addr_h <= GenAddr;
      gen_data_h <= GenData;
    end
    if (cap_ctrl) ctrl_addr_h <= CtrlAddr;
    if (cap_aux)  aux_addr_h  <= AuxAddr;
  end

  assign RamAddr   = ram_addr_q;
  assign RamWe     = ram_we_q;
  assign RamDin    = ram_din_q;
  assign GenAck    = gen_ack_q;
  assign CtrlValid = ctrl_valid_q;
  assign CtrlData  = ctrl_data_q;
  assign AuxValid  = aux_valid_q;
  assign AuxData   = aux_data_q;
  assign Overrun   = overrun_q;
  assign Busy      = (state_q != IDLE) || pend_gen_q || pend_ctrl_q || pend_aux_q;
endmodule

// File: tb/tb_seq_ram_arbiter.sv
// Bench for seq_ram_arbiter: a directed cycle table, hand-written reset/flush sequences, and random traffic checked against a transaction-level model.
module tb_seq_ram_arbiter;
  localparam int AW = 5, DW = 4, LAT = 2;

  logic          Clk = 1'b0, Rst, Flush, GenReq, CtrlReq, AuxReq;
  logic [AW-1:0] GenAddr, CtrlAddr, AuxAddr, RamAddr;
  logic [DW-1:0] GenData, CtrlData, AuxData, RamDin, RamDout;
  logic          GenAck, CtrlValid, AuxValid, RamWe, Busy, Overrun;
  int            n_vec = 0, n_err = 0;

  seq_ram_arbiter #(.RAM_LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .GenReq(GenReq), .GenAddr(GenAddr), .GenData(GenData), .GenAck(GenAck),
    .CtrlReq(CtrlReq), .CtrlAddr(CtrlAddr), .CtrlData(CtrlData), .CtrlValid(CtrlValid),
    .AuxReq(AuxReq), .AuxAddr(AuxAddr), .AuxData(AuxData), .AuxValid(AuxValid),
    .RamAddr(RamAddr), .RamWe(RamWe), .RamDin(RamDin), .RamDout(RamDout),
    .Busy(Busy), .Overrun(Overrun));

  always #5 Clk = ~Clk;

  // RAM device: combinational array read plus one output register gives a 2-cycle latency.
  logic [DW-1:0] ram [32];
  logic [DW-1:0] ram_rd_q;
  logic          ram_init;
  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 3 + 1);
  endfunction
  always @(posedge Clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
    end else if (RamWe) begin
      ram[RamAddr] <= RamDin;
    end
    ram_rd_q <= ram[RamAddr];
  end
  assign RamDout = ram_rd_q;

  typedef struct {
    logic gr; logic [4:0] ga; logic [3:0] gd;
    logic cr; logic [4:0] ca; logic ar; logic [4:0] aa; logic fl;
    logic [22:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [22:0] ex(input logic we, input logic [4:0] a, input logic [3:0] din,
                                     input logic ack, input logic cv, input logic [3:0] cd,
                                     input logic av, input logic [3:0] ad, input logic busy, input logic ovr);
    return {we, a, din, ack, cv, cd, av, ad, busy, ovr};
  endfunction

  function automatic vec_t mk(input logic gr, input logic [4:0] ga, input logic [3:0] gd,
                              input logic cr, input logic [4:0] ca, input logic ar, input logic [4:0] aa,
                              input logic fl, input logic [22:0] e);
    vec_t v;
    v.gr = gr; v.ga = ga; v.gd = gd; v.cr = cr; v.ca = ca; v.ar = ar; v.aa = aa; v.fl = fl; v.exp = e;
    return v;
  endfunction

  function automatic logic [22:0] outs();
    return {RamWe, RamAddr, RamDin, GenAck, CtrlValid, CtrlData, AuxValid, AuxData, Busy, Overrun};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_inputs();
    Flush = 0; GenReq = 0; CtrlReq = 0; AuxReq = 0;
    GenAddr = '0; GenData = '0; CtrlAddr = '0; AuxAddr = '0;
  endtask

  task automatic rst_pulse();
    #2 Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic do_read(input logic aux, input logic [4:0] a, input logic [3:0] exp, input string nm);
    logic got;
    logic [3:0] d;
    got = 0; d = '0;
    if (aux) begin AuxReq = 1; AuxAddr = a; end
    else begin CtrlReq = 1; CtrlAddr = a; end
    step();
    AuxReq = 0; CtrlReq = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (aux ? AuxValid : CtrlValid) begin
        got = 1;
        d = aux ? AuxData : CtrlData;
        break;
      end
    end
    chk({nm, " valid"}, 23'(got), 23'd1);
    chk({nm, " data"}, 23'(d), 23'(exp));
  endtask

  task automatic do_write(input logic [4:0] a, input logic [3:0] d, input string nm);
    logic got;
    got = 0;
    GenReq = 1; GenAddr = a; GenData = d;
    step();
    GenReq = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (GenAck) begin got = 1; break; end
    end
    chk({nm, " ack"}, 23'(got), 23'd1);
  endtask

  // Reference-model state for the random phase.
  logic [3:0]  rmem [32];
  logic [2:0]  pm;
  logic [4:0]  ha [3];
  logic [3:0]  hd, cur_d;
  logic [4:0]  cur_a;
  int          cur, done_at, cyc;
  logic        m_we, m_ack, m_cv, m_av, m_busy, m_ovr;
  logic [4:0]  m_addr;
  logic [3:0]  m_din, m_cd, m_ad;
`ifdef ARB_RR_EN
  logic        rr_m;
`endif

  initial begin
    clr_inputs();
    Rst = 1'b1; ram_init = 1'b1;
    step();
    chk("reset outputs", outs(), 23'd0);
    ram_init = 1'b0;
    Rst = 1'b0;

    // Directed cycle table: inputs before an edge and all outputs after it.
    tbl.push_back(mk(1, 3, 9, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(1, 3, 9, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 9, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, ex(0, 3, 9, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 9, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 9, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 9, 0, 0, 0, 1, 9, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 9, 0, 0, 0, 0, 9, 0, 0)));
    tbl.push_back(mk(1, 7, 5, 1, 7, 1, 3, 0, ex(0, 3, 9, 0, 0, 0, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(1, 7, 5, 0, 0, 0, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 7, 5, 1, 0, 0, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 7, 5, 0, 0, 0, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 7, 5, 0, 0, 0, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 7, 5, 0, 1, 5, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 5, 0, 0, 5, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 5, 0, 0, 5, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 5, 0, 0, 5, 1, 9, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, ex(0, 3, 5, 0, 0, 5, 0, 9, 1, 0)));
    tbl.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, ex(0, 3, 5, 0, 0, 5, 0, 9, 1, 1)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 5, 0, 0, 5, 0, 9, 1, 1)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 5, 0, 1, 9, 0, 9, 0, 1)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 5, 0, 0, 9, 0, 9, 0, 1)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 5, 0, 0, 9, 0, 9, 0, 1)));
    foreach (tbl[i]) begin
      GenReq = tbl[i].gr; GenAddr = tbl[i].ga; GenData = tbl[i].gd;
      CtrlReq = tbl[i].cr; CtrlAddr = tbl[i].ca;
      AuxReq = tbl[i].ar; AuxAddr = tbl[i].aa; Flush = tbl[i].fl;
      step();
      chk($sformatf("table row %0d", i), outs(), tbl[i].exp);
    end
    clr_inputs();

    // Flush while a Ctrl read is in flight and Aux is still queued.
    rst_pulse();
    chk("reset clears overrun", 23'(Overrun), 23'd0);
    CtrlReq = 1; CtrlAddr = 3; AuxReq = 1; AuxAddr = 7;
    step();
    clr_inputs();
    step();
    Flush = 1;
    step();
    Flush = 0;
    chk("flush busy in flight", 23'(Busy), 23'd1);
    step();
    chk("flush read completes", {18'd0, CtrlValid, CtrlData}, {18'd0, 1'b1, 4'd9});
    chk("flush busy after", 23'(Busy), 23'd0);
    begin
      logic seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        seen = seen | AuxValid | Busy;
      end
      chk("flush aux never served", 23'(seen), 23'd0);
    end

    // Asynchronous reset in the middle of a write.
    GenReq = 1; GenAddr = 9; GenData = 6;
    step();
    GenReq = 0;
    step();
    chk("write active before reset", 23'(RamWe), 23'd1);
    #3 Rst = 1'b1;
    #1 chk("async reset mid-write", outs(), 23'd0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    step();
    chk("no ack after reset", outs(), 23'd0);
    do_read(0, 9, init_val(9), "aborted write not stored");
    do_write(9, 6, "write after reset");
    do_read(1, 9, 4'd6, "read after reset");

    // Random traffic against the transaction-level model.
    rst_pulse();
    for (int i = 0; i < 32; i++) rmem[i] = ram[i];
    pm = '0; hd = '0; cur = -1; done_at = 0; cyc = 0; cur_a = '0; cur_d = '0;
    m_addr = '0; m_din = '0; m_cd = '0; m_ad = '0; m_ovr = 0;
    for (int i = 0; i < 3; i++) ha[i] = '0;
`ifdef ARB_RR_EN
    rr_m = 0;
`endif
    for (int c = 0; c < 500; c++) begin
      logic [2:0] rq;
      logic [4:0] ra [3];
      logic [3:0] rd;
      logic       fl, was_idle;
      int         dn, pk;
      rq = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0};
      for (int x = 0; x < 3; x++) ra[x] = 5'($urandom_range(0, 31));
      rd = 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 39) == 0);
      GenReq = rq[0]; GenAddr = ra[0]; GenData = rd;
      CtrlReq = rq[1]; CtrlAddr = ra[1];
      AuxReq = rq[2]; AuxAddr = ra[2]; Flush = fl;

      dn = (cur >= 0 && cyc == done_at) ? cur : -1;
      was_idle = (cur < 0);
      m_we = 0; m_ack = 0; m_cv = 0; m_av = 0;
      if (dn == 0) begin rmem[cur_a] = cur_d; m_ack = 1; end
      else if (dn == 1) begin m_cv = 1; m_cd = rmem[cur_a]; end
      else if (dn == 2) begin m_av = 1; m_ad = rmem[cur_a]; end
      if (dn >= 0) cur = -1;
      if (was_idle && !fl) begin
        if (pm[0]) begin
          cur = 0; cur_a = ha[0]; cur_d = hd; done_at = cyc + 1;
          m_we = 1; m_addr = cur_a; m_din = cur_d;
        end else if (pm[1] || pm[2]) begin
          pk = pm[1] ? 1 : 2;
`ifdef ARB_RR_EN
          if (pm[1] && pm[2] && rr_m) pk = 2;
          rr_m = (pk == 1);
`endif
          cur = pk; cur_a = ha[pk]; done_at = cyc + LAT; m_addr = cur_a;
        end
      end
      for (int x = 0; x < 3; x++) begin
        if (fl) pm[x] = 0;
        else if (rq[x] && (!pm[x] || dn == x)) begin
          pm[x] = 1; ha[x] = ra[x];
          if (x == 0) hd = rd;
        end else if (rq[x]) m_ovr = 1;
        else if (dn == x) pm[x] = 0;
      end
      m_busy = (cur >= 0) || (pm != 3'b000);

      step();
      clr_inputs();
      chk($sformatf("random cycle %0d", c), outs(),
          {m_we, m_addr, m_din, m_ack, m_cv, m_cd, m_av, m_ad, m_busy, m_ovr});
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
